float_div_iter: RTL and testbench



---
 rtl/float_div_pkg.sv | 22 ++
 rtl/float_div_mant_core.sv | 64 ++++++
 rtl/float_div_iter.sv | 170 +++++++++++++++++
 tb/tb_float_div_iter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_div_pkg.sv
// Shared definitions for the iterative single-precision float divider.
// Contents: default format widths and bias, FSM state encoding, the quiet NaN
// and all-ones exponent constants, and the restoring-step iteration count.
package float_div_pkg;

  localparam int DEF_EXP_W  = 8;
  localparam int DEF_MANT_W = 23;
  localparam int DEF_BIAS   = 127;

  // integer bit + fraction bits + normalization bit + guard bit
  localparam int ITER_CNT = DEF_MANT_W + 3;

  localparam logic [31:0]          QNAN    = 32'h7FC0_0000;
  localparam logic [DEF_EXP_W-1:0] INF_EXP = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIVIDE    = 2'd1,
    NORMALIZE = 2'd2
  } state_t;

endpackage

// File: rtl/float_div_mant_core.sv
// Restoring mantissa divider: one quotient bit per step.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   load            capture {1,mant} operands, clear quotient and counter
//   step            perform one restoring step
//   mant_a, mant_b  dividend / divisor significands (hidden 1 included)
//   quot            quotient bits, MSB first (integer bit at the top)
//   sticky          final partial remainder is non-zero
//   last            the current step is the final one
module float_div_mant_core
  import float_div_pkg::*;
#(
  parameter int MANT_W = DEF_MANT_W,
  parameter int ITERS  = ITER_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [MANT_W:0]   mant_a,
  input  logic [MANT_W:0]   mant_b,
  output logic [ITERS-1:0]  quot,
  output logic              sticky,
  output logic              last
);

  localparam int CNT_W = $clog2(ITERS);
  localparam int RW    = MANT_W + 1;

  // The remainder needs one extra bit: after the shift it can reach 2x divisor.
  logic [MANT_W+1:0] rem;
  logic [MANT_W:0]   dvsr;
  logic [CNT_W-1:0]  iter;
  logic              ge;
  logic [MANT_W:0]   rem_sub;

  assign ge = (rem >= {1'b0, dvsr});

  // After a successful subtract the remainder is below the divisor, so the
  // top bit is always zero and can be dropped before the shift.
  assign rem_sub = ge ? RW'(rem - {1'b0, dvsr}) : RW'(rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      dvsr <= '0;
      quot <= '0;
      iter <= '0;
    end else if (load) begin
      rem  <= {1'b0, mant_a};
      dvsr <= mant_b;
      quot <= '0;
      iter <= '0;
    end else if (step) begin
      rem  <= {rem_sub, 1'b0};
      quot <= {quot[ITERS-2:0], ge};
      iter <= iter + 1'b1;
    end
  end

  assign sticky = |rem;
  assign last   = (iter == CNT_W'(ITERS - 1));

endmodule

// File: rtl/float_div_iter.sv
// Sequential IEEE-754 divider, result = A / B, start/busy/done handshake.
// Fixed latency: done pulses in the cycle after the 27th edge following the
// start-accept edge, for every input including the special cases.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   start        request, sampled only in IDLE (also in the done cycle)
//   A, B         dividend / divisor
//   busy         operation in flight
//   done         one-cycle pulse when result updates
//   result       quotient, held between completions
// Build option: define FLOAT_DIV_ROUND_EN for round-to-nearest-even;
// otherwise the quotient is truncated.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | waiting for start; result held
// DIVIDE    | one restoring quotient bit per edge, MANT_W+3 edges
// NORMALIZE | align, (round), pack, write result, pulse done
module float_div_iter
  import float_div_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W,
  parameter int BIAS   = DEF_BIAS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [EXP_W+MANT_W:0]   A,
  input  logic [EXP_W+MANT_W:0]   B,
  output logic                    busy,
  output logic                    done,
  output logic [EXP_W+MANT_W:0]   result
);

  localparam int W     = EXP_W + MANT_W + 1;
  localparam int EW    = EXP_W + 2;
  localparam int ITERS = MANT_W + 3;

  localparam logic [EXP_W-1:0] EXP_ONES =
    (EXP_W == DEF_EXP_W) ? EXP_W'(INF_EXP) : {EXP_W{1'b1}};
  localparam logic [W-1:0] NAN_VAL =
    (W == 32) ? W'(QNAN) : {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

  state_t state, state_nxt;
  logic   load, step, fin;

  logic                 sign_r;
  logic signed [EW-1:0] exp_base_r;
  logic                 nan_r, zero_r, inf_r;

  logic [ITERS-1:0] quot;
  logic             core_sticky;
  logic             core_last;

  logic                 a_zero, b_zero;
  logic signed [EW-1:0] exp_base_in;
  logic                 norm;
  logic [MANT_W-1:0]    mant_n, mant_f;
  logic signed [EW-1:0] exp_n, exp_f;
  logic [W-1:0]         res_nxt;

  float_div_mant_core #(
    .MANT_W (MANT_W),
    .ITERS  (ITERS)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .mant_a ({1'b1, A[MANT_W-1:0]}),
    .mant_b ({1'b1, B[MANT_W-1:0]}),
    .quot   (quot),
    .sticky (core_sticky),
    .last   (core_last)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = DIVIDE;
      DIVIDE:    if (core_last) state_nxt = NORMALIZE;
      NORMALIZE: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    fin  = 1'b0;
    busy = 1'b0;
    case (state)
      IDLE:      load = start;
      DIVIDE:    begin step = 1'b1; busy = 1'b1; end
      NORMALIZE: begin fin  = 1'b1; busy = 1'b1; end
      default:   ;
    endcase
  end

  assign a_zero      = ~|A[W-2:0];
  assign b_zero      = ~|B[W-2:0];
  assign exp_base_in = $signed({2'b00, A[W-2:MANT_W]})
                     - $signed({2'b00, B[W-2:MANT_W]})
                     + EW'(BIAS);

  // Integer bit clear means mant A < mant B: take the bits one position lower.
  assign norm   = ~quot[ITERS-1];
  assign mant_n = norm ? quot[MANT_W:1] : quot[MANT_W+1:2];
  assign exp_n  = exp_base_r - $signed({{(EW-1){1'b0}}, norm});

`ifdef FLOAT_DIV_ROUND_EN
  logic            guard, sticky_all, inc;
  logic [MANT_W:0] mant_sum;

  // Without the shift, the bit below the guard also folds into sticky.
  assign guard      = norm ? quot[0] : quot[1];
  assign sticky_all = core_sticky | (~norm & quot[0]);
  assign inc        = guard & (sticky_all | mant_n[0]);
  assign mant_sum   = {1'b0, mant_n} + {{MANT_W{1'b0}}, inc};
  assign mant_f     = mant_sum[MANT_W-1:0];
  assign exp_f      = exp_n + $signed({{(EW-1){1'b0}}, mant_sum[MANT_W]});
`else
  logic unused_rnd;
  assign unused_rnd = quot[0] ^ core_sticky;
  assign mant_f     = mant_n;
  assign exp_f      = exp_n;
`endif

  always_comb begin
    res_nxt = {sign_r, exp_f[EXP_W-1:0], mant_f};
    if (nan_r)
      res_nxt = NAN_VAL;
    else if (zero_r || exp_n[EW-1] || (exp_n == '0))
      res_nxt = {sign_r, {(W-1){1'b0}}};
    else if (inf_r || (exp_f >= $signed({2'b00, EXP_ONES})))
      res_nxt = {sign_r, EXP_ONES, {MANT_W{1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r     <= 1'b0;
      exp_base_r <= '0;
      nan_r      <= 1'b0;
      zero_r     <= 1'b0;
      inf_r      <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      done <= fin;
      if (load) begin
        sign_r     <= A[W-1] ^ B[W-1];
        exp_base_r <= exp_base_in;
        nan_r      <= a_zero & b_zero;
        zero_r     <= a_zero;
        inf_r      <= b_zero;
      end
      if (fin) result <= res_nxt;
    end
  end

endmodule

// File: tb/tb_float_div_iter.sv
`timescale 1ns/1ps
module tb_float_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done;
  logic [31:0] result;

  float_div_iter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (a_in),
    .B      (b_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

`ifdef FLOAT_DIV_ROUND_EN
  localparam bit ROUND = 1'b1;
  localparam logic [31:0] THIRD = 32'h3EAA_AAAB;
`else
  localparam bit ROUND = 1'b0;
  localparam logic [31:0] THIRD = 32'h3EAA_AAAA;
`endif

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } sb_t;

  sb_t         sb[$];
  int          done_log[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          last_acc = 0;
  bit          has_acc = 1'b0;
  logic [31:0] exp_cur = '0;

  // Reference: exact integer quotient of the significands, then IEEE packing.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint ma, mb, num, q, r, mant;
    int     e;
    logic   s;
    bit     g, st;
    s = a[31] ^ b[31];
    if (a[30:0] == 0 && b[30:0] == 0) return 32'h7FC0_0000;
    if (a[30:0] == 0) return {s, 31'b0};
    if (b[30:0] == 0) return {s, 8'hFF, 23'b0};
    ma  = longint'({1'b1, a[22:0]});
    mb  = longint'({1'b1, b[22:0]});
    num = ma << 25;
    q   = num / mb;
    r   = num % mb;
    e   = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= (longint'(1) << 25)) begin
      mant = (q >> 2) & 64'h7F_FFFF;
      g    = ((q >> 1) & 1) != 0;
      st   = ((q & 1) != 0) || (r != 0);
    end else begin
      e    = e - 1;
      mant = (q >> 1) & 64'h7F_FFFF;
      g    = (q & 1) != 0;
      st   = (r != 0);
    end
    if (e <= 0) return {s, 31'b0};
    if (ROUND && g && (st || ((mant & 1) != 0))) begin
      mant = mant + 1;
      if (mant == 64'h80_0000) begin
        mant = 0;
        e    = e + 1;
      end
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Acceptance tracker: decides from the handshake rules alone when a start
  // is taken, and records the expected result at that moment.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rst_n && start && (!has_acc || cyc > last_acc + 27)) begin
      sb.push_back('{exp_cur, cyc});
      last_acc = cyc;
      has_acc  = 1'b1;
      n_acc++;
    end
  end

  // Monitor: busy every cycle, done/result exactly 27 edges after acceptance.
  initial forever begin
    logic exp_busy;
    @(negedge clk);
    if (rst_n) begin
      exp_busy = has_acc && (cyc <= last_acc + 26);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
      end
      if (sb.size() > 0 && cyc == sb[0].acc + 27) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL done_latency cyc=%0d got done=%b want 1", cyc, done);
        end
        checks++;
        if (result !== sb[0].exp) begin
          errors++;
          $display("FAIL result acc=%0d got=%h want=%h", sb[0].acc, result, sb[0].exp);
        end
        done_log.push_back(cyc);
        void'(sb.pop_front());
      end else begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d got=%b want 0", cyc, done);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    a_in    = a;
    b_in    = b;
    exp_cur = e;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 100 && cyc != target; i++) @(negedge clk);
  endtask

  logic [31:0] dir_a [9] = '{32'h40C0_0000, 32'h3F80_0000, 32'hBFC0_0000,
                             32'h3F80_0000, 32'h8000_0000, 32'h0000_0000,
                             32'h7F00_0000, 32'h0080_0000, 32'h3F80_0000};
  logic [31:0] dir_b [9] = '{32'h4000_0000, 32'h4040_0000, 32'h3F00_0000,
                             32'h0000_0000, 32'h40A0_0000, 32'h0000_0000,
                             32'h0080_0000, 32'h7F00_0000, 32'h3F80_0000};
  logic [31:0] dir_e [9] = '{32'h4040_0000, THIRD,        32'hC040_0000,
                             32'h7F80_0000, 32'h8000_0000, 32'h7FC0_0000,
                             32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000};

  initial begin
    logic [31:0] ra, rb;
    int          tgt;

    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      issue(dir_a[k], dir_b[k], dir_e[k]);
      drain();
    end

    // start re-pulsed mid-operation must be ignored
    issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
    wait_cyc(last_acc + 10);
    a_in    = 32'h3F80_0000;
    b_in    = 32'h4040_0000;
    exp_cur = 32'hDEAD_BEEF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // reset in the middle of an operation
    issue(32'h3F80_0000, 32'h4040_0000, THIRD);
    wait_cyc(last_acc + 15);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_done", {31'b0, done}, 32'h0);
    chk("midrst_result", result, 32'h0);
    sb.delete();
    has_acc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'hBFC0_0000, 32'h3F00_0000, 32'hC040_0000);
    drain();

    // start held high: back-to-back every 28 cycles
    done_log.delete();
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ra = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
      rb = {1'b1, 8'($urandom_range(100, 150)), 23'($urandom)};
      a_in    = ra;
      b_in    = rb;
      exp_cur = ref_div(ra, rb);
      tgt = n_acc + 1;
      for (int i = 0; i < 100 && n_acc < tgt; i++) @(negedge clk);
    end
    start = 1'b0;
    drain();
    chk("b2b_count", done_log.size(), 32'd3);
    if (done_log.size() == 3) begin
      chk("b2b_period1", done_log[1] - done_log[0], 32'd28);
      chk("b2b_period2", done_log[2] - done_log[1], 32'd28);
    end

    // randomized operands against the reference model
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) != 0) ra[30:23] = 8'($urandom_range(64, 190));
      if ($urandom_range(0, 3) != 0) rb[30:23] = 8'($urandom_range(64, 190));
      if ($urandom_range(0, 9) == 0) ra[30:0] = '0;
      if ($urandom_range(0, 9) == 0) rb[30:0] = '0;
      if ($urandom_range(0, 5) == 0) rb[22:0] = ra[22:0];
      issue(ra, rb, ref_div(ra, rb));
      drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    drain();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
